// File: rtl/intseq.sv
// intseq: 6502 reset/NMI/IRQ/BRK vector sequencer (stack pushes and vector fetch)
module intseq #(
    parameter logic [7:0] NMI_VEC = 8'hFA,
    parameter logic [7:0] RST_VEC = 8'hFC,
    parameter logic [7:0] IRQ_VEC = 8'hFE
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       iflag,
    input  logic       brk,
    input  logic       fetch,
    output logic       busy,
    output logic       setreset,
    output logic       setirq,
    output logic       setnmi,
    output logic       pchdboa,
    output logic       pcldboa,
    output logic       pdboa,
    output logic       memwe,
    output logic       spdec,
    output logic       adloa,
    output logic [7:0] adlout,
    output logic       pclwa,
    output logic       adhwa,
    output logic       iset,
    output logic       bflag
);
    typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI} state_t;
    typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} kind_t;

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic       brk_q, brk_d;
    logic       nmi_prev_q, nmi_prev_d;
    logic       nmipend_q, nmipend_d;
    logic       push;
    logic [7:0] vec_lo;

    // State, kind, B-flag and NMI edge-detect registers; reset parks in a RESET push sequence
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= PUSH_PCH;
            kind_q     <= K_RESET;
            brk_q      <= 1'b0;
            nmi_prev_q <= 1'b1;
            nmipend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            brk_q      <= brk_d;
            nmi_prev_q <= nmi_prev_d;
            nmipend_q  <= nmipend_d;
        end
    end

    // Acceptance at fetch, NMI hijack of IRQ/BRK in PUSH_PCL, fixed five-cycle sequence
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        brk_d      = brk_q;
        nmi_prev_d = nmi_n;
        nmipend_d  = (nmi_prev_q & ~nmi_n) | (nmipend_q & ~(state_q == VEC_LO && kind_q == K_NMI));
        case (state_q)
            IDLE: begin
                if (fetch && nmipend_q) begin
                    state_d = PUSH_PCH;
                    kind_d  = K_NMI;
                    brk_d   = 1'b0;
                end else if (fetch && brk) begin
                    state_d = PUSH_PCH;
                    kind_d  = K_BRK;
                    brk_d   = 1'b1;
                end else if (fetch && !irq_n && !iflag) begin
                    state_d = PUSH_PCH;
                    kind_d  = K_IRQ;
                    brk_d   = 1'b0;
                end
            end
            PUSH_PCH: state_d = PUSH_PCL;
            PUSH_PCL: begin
                state_d = PUSH_P;
                if ((kind_q == K_IRQ || kind_q == K_BRK) && nmipend_d)
                    kind_d = K_NMI;
            end
            PUSH_P:  state_d = VEC_LO;
            VEC_LO:  state_d = VEC_HI;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state/kind, forced low while reset is asserted
    always_comb begin
        push     = rstn && (state_q == PUSH_PCH || state_q == PUSH_PCL || state_q == PUSH_P);
        vec_lo   = (kind_q == K_NMI) ? NMI_VEC : (kind_q == K_RESET) ? RST_VEC : IRQ_VEC;
        busy     = rstn && state_q != IDLE;
        pchdboa  = rstn && state_q == PUSH_PCH;
        pcldboa  = rstn && state_q == PUSH_PCL;
        pdboa    = rstn && state_q == PUSH_P;
        spdec    = push;
        memwe    = push && kind_q != K_RESET;
        setreset = pdboa && kind_q == K_RESET;
        setnmi   = pdboa && kind_q == K_NMI;
        setirq   = pdboa && (kind_q == K_IRQ || kind_q == K_BRK);
        bflag    = pdboa && brk_q;
        pclwa    = rstn && state_q == VEC_LO;
        iset     = pclwa;
        adhwa    = rstn && state_q == VEC_HI;
        adloa    = pclwa || adhwa;
        adlout   = pclwa ? vec_lo : adhwa ? vec_lo + 8'd1 : 8'h00;
    end
endmodule

// File: tb/tb_intseq.sv
// tb_intseq: directed and random stimulus checked against a cycle-step reference model
module tb_intseq;
    logic       clk, rstn, nmi_n, irq_n, iflag, brk, fetch;
    logic       busy, setreset, setirq, setnmi, pchdboa, pcldboa, pdboa, memwe, spdec;
    logic       adloa, pclwa, adhwa, iset, bflag;
    logic [7:0] adlout;

    int total = 0, bad = 0;
    int step, kind;
    bit brkb, pend, prev, inrst;

    intseq dut (
        .clk(clk), .rstn(rstn), .nmi_n(nmi_n), .irq_n(irq_n), .iflag(iflag), .brk(brk),
        .fetch(fetch), .busy(busy), .setreset(setreset), .setirq(setirq), .setnmi(setnmi),
        .pchdboa(pchdboa), .pcldboa(pcldboa), .pdboa(pdboa), .memwe(memwe), .spdec(spdec),
        .adloa(adloa), .adlout(adlout), .pclwa(pclwa), .adhwa(adhwa), .iset(iset), .bflag(bflag)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0=RESET 1=NMI 2=IRQ 3=BRK; step: 0 idle, 1..5 sequence cycle
    task automatic check_outputs();
        logic [13:0] got, exp;
        logic [7:0]  eadl;
        bit a, p;
        got = {busy, setreset, setirq, setnmi, pchdboa, pcldboa, pdboa, memwe, spdec,
               adloa, pclwa, adhwa, iset, bflag};
        p = step >= 1 && step <= 3;
        a = step >= 4;
        exp = {step != 0, step == 3 && kind == 0, step == 3 && kind >= 2, step == 3 && kind == 1,
               step == 1, step == 2, step == 3, p && kind != 0, p,
               a, step == 4, step == 5, step == 4, step == 3 && brkb};
        eadl = !a ? 8'h00 : ((kind == 1) ? 8'hFA : (kind == 0) ? 8'hFC : 8'hFE) + ((step == 5) ? 8'd1 : 8'd0);
        if (inrst) begin
            exp = '0;
            eadl = 8'h00;
        end
        chk("flags", {18'd0, got}, {18'd0, exp});
        chk("adlout", {24'd0, adlout}, {24'd0, eadl});
    endtask

    task automatic model_step();
        bit fall, pn;
        fall = prev && !nmi_n;
        pn = fall || (pend && !(step == 4 && kind == 1));
        if (step == 0) begin
            if (fetch && pend) begin kind = 1; brkb = 0; step = 1; end
            else if (fetch && brk) begin kind = 3; brkb = 1; step = 1; end
            else if (fetch && !irq_n && !iflag) begin kind = 2; brkb = 0; step = 1; end
        end else begin
            if (step == 2 && kind >= 2 && pn) kind = 1;
            step = (step == 5) ? 0 : step + 1;
        end
        pend = pn;
        prev = nmi_n;
    endtask

    task automatic cyc(input logic f, input logic b, input logic irqn, input logic ifl, input logic nmin);
        fetch = f; brk = b; irq_n = irqn; iflag = ifl; nmi_n = nmin;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rstn = 0;
        inrst = 1; step = 1; kind = 0; brkb = 0; pend = 0; prev = 1;
        #1;
        check_outputs();
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
        end
        #1;
        rstn = 1;
        inrst = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 1, 0, 1);
    endtask

    initial begin
        bit nm;
        fetch = 0; brk = 0; irq_n = 1; iflag = 0; nmi_n = 1;
        do_reset(3);
        idle(7);
        cyc(1, 0, 0, 0, 1);
        idle(7);
        cyc(1, 0, 0, 1, 1);
        idle(2);
        cyc(1, 1, 1, 1, 1);
        idle(7);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (9) cyc(1, 0, 1, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        repeat (5) cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(1, 0, 1, 0, 1);
        idle(2);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        idle(7);
        cyc(1, 0, 0, 0, 1);
        idle(3);
        do_reset(2);
        idle(7);
        nm = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) nm = ~nm;
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
            cyc($urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1), nm);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
